// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: upstream sequencer for the LED pattern state blocks.
// Walks ST(0)..ST(NUM_ST-1) in order, handing a one-hot begin to one block at a
// time, muxes the active block's pattern onto a registered LED bus, guards each
// state with a watchdog and counts completed full sequences.
module led_seq_ctrl #(
   parameter int LED_W   = 18,
   parameter int NUM_ST  = 4,
   parameter int TIMEOUT = 1024,
   parameter int WD_W    = 16
) (
   input  logic                      clk,
   input  logic                      async_rs,
   input  logic                      run,
   input  logic [NUM_ST-1:0]         st_over,
   input  logic [NUM_ST*LED_W-1:0]   st_out,
   output logic [NUM_ST-1:0]         st_begin,
   output logic                      st_en,
   output logic [LED_W-1:0]          led_out,
   output logic                      fault,
   output logic [7:0]                cycle_cnt
);

   localparam int                IDX_W    = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ST - 1);
   // Last watchdog value allowed in a state; only meaningful when TIMEOUT != 0.
   localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   // ST_ACT covers every ST(i); the active block number lives in idx.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACT   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [WD_W-1:0]   wd;

   logic              cur_done;
   logic              wd_expire;
   logic [IDX_W-1:0]  nxt_idx;
   logic [LED_W-1:0]  cur_slice;

   function automatic logic [NUM_ST-1:0] onehot(input logic [IDX_W-1:0] i);
      return NUM_ST'(1) << i;
   endfunction

   // Decode of the active block: its done flag, its pattern and its successor.
   always_comb begin
      cur_done  = st_over[idx];
      cur_slice = st_out[idx*LED_W +: LED_W];
      nxt_idx   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      wd_expire = (TIMEOUT != 0) && (wd == WD_LIMIT);
   end

   // Sequencer FSM with registered outputs; run=0 overrides every state.
   always_ff @(posedge clk or negedge async_rs) begin
      if (!async_rs) begin
         state     <= S_IDLE;
         idx       <= '0;
         wd        <= '0;
         st_begin  <= '0;
         st_en     <= 1'b0;
         led_out   <= '0;
         fault     <= 1'b0;
         cycle_cnt <= 8'd0;
      end else if (!run) begin
         // cycle_cnt deliberately survives a stop/start.
         state    <= S_IDLE;
         idx      <= '0;
         wd       <= '0;
         st_begin <= '0;
         st_en    <= 1'b0;
         led_out  <= '0;
         fault    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Always start from block 0; LED stays dark until the block's
               // pattern has been sampled once.
               state    <= S_ACT;
               idx      <= '0;
               wd       <= '0;
               st_begin <= onehot('0);
               st_en    <= 1'b1;
               led_out  <= '0;
               fault    <= 1'b0;
            end
            S_ACT: begin
               if (cur_done) begin
                  // Done beats a simultaneous watchdog expiry. Direct handover:
                  // old begin bit falls as the new one rises.
                  idx      <= nxt_idx;
                  wd       <= '0;
                  st_begin <= onehot(nxt_idx);
                  led_out  <= cur_slice;
                  if (idx == LAST_IDX) begin
                     cycle_cnt <= cycle_cnt + 8'd1;
                  end
               end else if (wd_expire) begin
                  state    <= S_FAULT;
                  wd       <= '0;
                  st_begin <= '0;
                  st_en    <= 1'b0;
                  led_out  <= '1;
                  fault    <= 1'b1;
               end else begin
                  led_out <= cur_slice;
                  // With the watchdog disabled the counter is parked so it
                  // can never wrap.
                  if (TIMEOUT != 0) begin
                     wd <= wd + WD_W'(1);
                  end
               end
            end
            S_FAULT: begin
               // Sticky until run drops.
               st_begin <= '0;
               st_en    <= 1'b0;
               led_out  <= '1;
               fault    <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               idx      <= '0;
               wd       <= '0;
               st_begin <= '0;
               st_en    <= 1'b0;
               led_out  <= '0;
               fault    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Upstream sequencer for the LED pattern state blocks.
- Issues a one-hot begin to exactly one state block at a time and advances to the next block when the active one reports done.
- Muxes the active block's 18-bit pattern onto the LED bus.
- Adds a per-state watchdog and a completed-sequence counter.

Parameters:
- LED_W, 18: LED bus width, and the width of each state block's pattern.
- NUM_ST, 4: number of state blocks sequenced; legal range 2..8.
- TIMEOUT, 1024: maximum cycles allowed in one state before fault; 0 disables the watchdog.
- WD_W, 16: watchdog counter width; TIMEOUT must be below 2^WD_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- async_rs  in  1  reset, asynchronous and active-low.
- run  in  1  level; 1 = sequence runs, 0 = return to idle.
- st_over  in  NUM_ST  done flags from the state blocks; bit i belongs to block i.
- st_out  in  NUM_ST*LED_W  concatenated patterns; block i occupies [i*LED_W +: LED_W].
- st_begin  out  NUM_ST  one-hot begin to the state blocks.
- st_en  out  1  enabler to all state blocks.
- led_out  out  LED_W  registered LED drive.
- fault  out  1  watchdog fault flag.
- cycle_cnt  out  8  number of completed full sequences.

Behaviour:
- Reset (async_rs=0, asynchronous):
  - FSM goes to IDLE.
  - st_begin=0, st_en=0, led_out=0, fault=0, cycle_cnt=0, watchdog=0.
- States are IDLE, ST(0)..ST(NUM_ST-1) and FAULT.
- Priority every edge: run=0 is highest and forces IDLE from any state at the next edge. cycle_cnt is held, not cleared.
- IDLE:
  - If run=1, go to ST(0) at the next edge.
  - Outputs: st_begin=0, st_en=0, led_out=0.
- ST(i) outputs:
  - st_begin = one-hot bit i.
  - st_en=1.
  - led_out <= st_out slice i, registered, so there is 1 cycle of latency from st_out to led_out.
- ST(i) exit on done: when st_over[i]=1 is sampled, go to ST(i+1) at the next edge.
  - From the last state, wrap to ST(0) and increment cycle_cnt (mod 256).
  - The begin handover is direct: bit i falls and bit i+1 rises on the same edge, with no idle gap.
- ST(i) other inputs:
  - st_over bits j≠i are ignored.
  - st_over[i] held high is treated as a single advance, because the state has already changed by the next sample.
- Watchdog:
  - Cleared on every state entry; increments each cycle in ST(i).
  - If TIMEOUT≠0, the counter equals TIMEOUT-1, and st_over[i]=0, go to FAULT at that edge. At most TIMEOUT cycles are spent in any state.
  - If st_over[i]=1 and expiry occur in the same cycle, st_over wins: the FSM advances and there is no fault.
- FAULT:
  - st_begin=0, st_en=0, led_out = all ones, fault=1.
  - FAULT is sticky; exit only via run=0, which goes to IDLE and clears fault.
- run re-asserted after IDLE restarts at ST(0), never resuming mid-sequence.
- The watchdog never wraps; WD_W bounds TIMEOUT.

Test Plan (NUM_ST=2, LED_W=18, TIMEOUT=32 unless noted):
1. Reset, then run=1 → next edge st_begin=01, st_en=1. One edge later led_out equals st_out[17:0] (drive 18'h30000 → led_out 18'h30000).
2. In ST(0), pulse st_over[0] for 1 cycle → next edge st_begin=10 with no cycle at 00, and led_out follows slice 1 one cycle later. Pulse st_over[1] → st_begin=01, cycle_cnt 0→1. Repeat 256 sequences → cycle_cnt wraps to 0.
3. Hold st_over=0 in ST(0) → exactly 32 cycles in ST(0), then fault=1, st_begin=00, st_en=0, led_out=18'h3FFFF. Assert st_over afterwards → no change. Then run=0 → IDLE, fault=0, led_out=0.
4. Assert st_over[0] in the same cycle the watchdog reaches 31 → advance to ST(1), fault stays 0. Assert st_over[1] while in ST(0) → ignored.
5. Drop run mid-ST(1) → next edge st_begin=00, st_en=0, led_out=0, cycle_cnt unchanged. Re-assert run → ST(0).
6. Assert async_rs=0 between clock edges mid-sequence → all outputs 0 immediately, without waiting for a clock edge. With TIMEOUT=0, hold st_over=0 for 5000 cycles → no fault.
